asi_reg32_bank: RTL and testbench
=================================

Name: asi_reg32_bank

Overview:
- Register-bank responder for the 32-bit register write/read channels produced by the ASI 128-to-32 register bridge.
- Accepts word-addressed writes with byte strobes and one-outstanding reads, and returns read data with a registered response.
- Holds the block's ID, control, status, interrupt and scratch registers.
- Drives configuration outputs and a level interrupt to the surrounding datapath.

Parameters:
AXI_SW, 3, width of size fields
REG_AW, 20, register byte-address width
REG_DW, 32, register data width
L, $clog2(REG_DW/8) = 2, byte-offset bits dropped from addresses
NREG, 16, number of word registers implemented (minimum 6)
NIRQ, 8, number of interrupt event inputs (≤ REG_DW)
ID_VALUE, 32'h0A51_0001, constant returned by register 0

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
s_wsize  in  AXI_SW  write transfer size (log2 bytes)
s_waddr  in  [REG_AW-1:L]  write word address
s_wdata  in  REG_DW  write data
s_wstrb  in  REG_DW/8  write byte strobes
s_wlast  in  1  last beat of burst (informational, no effect)
s_wvalid  in  1  write request valid
s_wready  out  1  write accepted
s_werr  out  1  one-cycle pulse: previous accepted write was rejected
s_rsize  in  AXI_SW  read transfer size
s_raddr  in  [REG_AW-1:L]  read word address
s_rvalid  in  1  read request valid (held until s_rready)
s_rdata  out  REG_DW  read data, valid while s_rready=1
s_rready  out  1  read response valid, one cycle
s_rerr  out  1  read error, qualified by s_rready
cfg_ctrl  out  REG_DW  CTRL register contents
cfg_start  out  1  one-cycle start pulse
cfg_scratch  out  (NREG-5)*REG_DW  registers 5..NREG-1, concatenated, reg5 at LSB
sts_i  in  REG_DW  live status value
irq_evt  in  NIRQ  interrupt event pulses
irq  out  1  level interrupt

Behaviour:
- Single clock domain on clk. Reset is synchronous and active-low on rst_n: sampled at the clk edge.

Reset values:
- s_wready=0, s_werr=0, s_rready=0, s_rerr=0, s_rdata=0, cfg_start=0, irq=0.
- All storage registers = 0.
- s_wready rises to 1 in the first cycle after rst_n=1 and stays 1.

Register map (word index = s_*addr):
- 0 ID: read-only, returns ID_VALUE.
- 1 CTRL: read/write.
  - Bit 0 is the start bit. Writing 1 with strobe[0] set pulses cfg_start for exactly 1 cycle, starting the cycle after the handshake.
  - Bit 0 never stores a value and always reads 0.
- 2 STATUS: read-only, returns sts_i sampled in the read request cycle.
- 3 IRQ_STAT: bits [NIRQ-1:0] are W1C; upper bits read 0.
- 4 IRQ_EN: bits [NIRQ-1:0] are read/write; upper bits read 0.
- 5..NREG-1 SCRATCH: read/write, mirrored on cfg_scratch.

Write handshake:
- Commits at the edge where s_wvalid & s_wready = 1.
- Each byte k is updated only if s_wstrb[k]=1.
- Zero latency: new value is visible on cfg_* and to reads issued in the next cycle.
- Writes to read-only registers are ignored without error.

Write error:
- Condition: s_wsize != L, or word index ≥ NREG.
- Effect: no register changes, and s_werr pulses 1 in the next cycle.

Read FSM (2 states):
- IDLE: on s_rvalid=1, capture the selected register value (or 0 plus error), then go to RESP.
- RESP: drive s_rready=1 with s_rdata and s_rerr, then return to IDLE.
- s_rvalid is ignored while in RESP.
- Peak throughput is one read per 2 cycles; latency from request to response is 1 cycle.
- s_rdata holds its last value while s_rready=0.

Read error:
- Condition: s_rsize != L, or word index ≥ NREG.
- Response: s_rdata=0 and s_rerr=1.

Simultaneous read and write:
- Both proceed in the same cycle.
- A read captured in the same cycle as a write to the same address returns the pre-write value.

Interrupts:
- IRQ_STAT[i] is set when irq_evt[i]=1.
- It is cleared by a write of 1 to bit i with its byte strobe set.
- When set and clear coincide, set wins.
- irq is registered: irq = |(IRQ_STAT & IRQ_EN[NIRQ-1:0]), delayed 1 cycle from the register update.

Reset mid-operation:
- A pending read response is dropped: s_rready=0 and the FSM goes to IDLE.
- An in-flight write is not committed.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release -> all outputs 0 during reset; s_wready=1 from the 1st cycle after release; read of index 0 -> s_rready=1 one cycle later with s_rdata=32'h0A51_0001, s_rerr=0.
- Strobed write: write index 5 with data 32'hDEADBEEF, strb 4'b0101, then read index 5 -> 32'h00AD00EF; cfg_scratch[31:0] matches.
- Start pulse: write CTRL with data 32'h0000_0013, strb 4'hF -> cfg_start=1 for exactly 1 cycle; cfg_ctrl=32'h12; read CTRL returns 32'h12.
- IRQ: set IRQ_EN=8'h04, pulse irq_evt[2] -> IRQ_STAT=8'h04 and irq=1 one cycle later. Write IRQ_STAT=8'h04 in the same cycle as a new irq_evt[2] pulse -> bit stays 1. Repeat the clear with no event -> irq=0 one cycle later.
- Errors:
  - Write with s_wsize=3 -> no update and s_werr pulse.
  - Read index 16 (NREG=16) -> s_rdata=0, s_rerr=1.
  - Write to ID -> ignored and s_werr=0.
- Concurrency/reset: same-cycle read and write of index 6 (old value 1, new value 2) -> read returns 1. Assert rst_n=0 in the cycle s_rready would rise -> s_rready stays 0.

Source files
------------

// File: rtl/asi_reg32_bank.sv
// Register-bank responder for the 32-bit register channels of the ASI 128-to-32 bridge.
// Holds ID/CTRL/STATUS/IRQ/scratch registers, with strobed writes and a registered read response.
module asi_reg32_bank #(
  parameter int unsigned            AXI_SW   = 3,
  parameter int unsigned            REG_AW   = 20,
  parameter int unsigned            REG_DW   = 32,
  localparam int unsigned           L        = $clog2(REG_DW / 8),
  parameter int unsigned            NREG     = 16,
  parameter int unsigned            NIRQ     = 8,
  parameter logic [REG_DW-1:0]      ID_VALUE = 32'h0A51_0001
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AXI_SW-1:0]          s_wsize,
  input  logic [REG_AW-1:L]          s_waddr,
  input  logic [REG_DW-1:0]          s_wdata,
  input  logic [REG_DW/8-1:0]        s_wstrb,
  input  logic                       s_wlast,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  output logic                       s_werr,
  input  logic [AXI_SW-1:0]          s_rsize,
  input  logic [REG_AW-1:L]          s_raddr,
  input  logic                       s_rvalid,
  output logic [REG_DW-1:0]          s_rdata,
  output logic                       s_rready,
  output logic                       s_rerr,
  output logic [REG_DW-1:0]          cfg_ctrl,
  output logic                       cfg_start,
  output logic [(NREG-5)*REG_DW-1:0] cfg_scratch,
  input  logic [REG_DW-1:0]          sts_i,
  input  logic [NIRQ-1:0]            irq_evt,
  output logic                       irq
);

  localparam int unsigned NB  = REG_DW / 8;
  localparam int unsigned WAW = REG_AW - L;

  typedef enum logic [0:0] {StIdle, StResp} rd_state_e;

  rd_state_e         state_q, state_d;
  logic              wready_q, werr_q, start_q, start_d, irq_q;
  logic [REG_DW-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;
  logic [REG_DW-1:0] ctrl_q, ctrl_d;
  logic [NIRQ-1:0]   irq_stat_q, irq_stat_d, irq_en_q, irq_en_d, irq_clr;
  logic [REG_DW-1:0] scratch_q [NREG-5];
  logic [REG_DW-1:0] scratch_d [NREG-5];

  logic              wr_fire, wr_err, wr_ok, rd_err;
  logic [NREG-1:0]   wr_sel;
  logic [REG_DW-1:0] wmask, rd_word;
  logic [REG_DW-1:0] rd_view [NREG];

  // Burst framing carries no meaning for single-word register accesses.
  logic unused_wlast;
  assign unused_wlast = s_wlast;

  function automatic logic [REG_DW-1:0] merge(input logic [REG_DW-1:0] old_val,
                                               input logic [REG_DW-1:0] new_val,
                                               input logic [REG_DW-1:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  assign wr_fire = s_wvalid & wready_q;
  assign wr_err  = (s_wsize != AXI_SW'(L)) || (s_waddr >= WAW'(NREG));
  assign wr_ok   = wr_fire & ~wr_err;
  assign rd_err  = (s_rsize != AXI_SW'(L)) || (s_raddr >= WAW'(NREG));

  always_comb begin
    wmask  = '0;
    wr_sel = '0;
    for (int k = 0; k < NB; k++) wmask[k*8 +: 8] = {8{s_wstrb[k]}};
    for (int i = 0; i < NREG; i++) wr_sel[i] = wr_ok && (s_waddr == WAW'(i));
  end

  // Next state of the storage registers; ID and STATUS have no storage, so writes there vanish.
  always_comb begin
    ctrl_d    = ctrl_q;
    irq_en_d  = irq_en_q;
    scratch_d = scratch_q;
    start_d   = 1'b0;
    irq_clr   = '0;
    if (wr_sel[1]) begin
      ctrl_d    = merge(ctrl_q, s_wdata, wmask);
      ctrl_d[0] = 1'b0;
      start_d   = s_wstrb[0] & s_wdata[0];
    end
    if (wr_sel[3]) irq_clr = s_wdata[NIRQ-1:0] & wmask[NIRQ-1:0];
    if (wr_sel[4]) begin
      irq_en_d = (irq_en_q & ~wmask[NIRQ-1:0]) | (s_wdata[NIRQ-1:0] & wmask[NIRQ-1:0]);
    end
    for (int i = 5; i < NREG; i++) begin
      if (wr_sel[i]) scratch_d[i-5] = merge(scratch_q[i-5], s_wdata, wmask);
    end
    // New events override a same-cycle clear.
    irq_stat_d = (irq_stat_q & ~irq_clr) | irq_evt;
  end

  always_comb begin
    rd_view[0] = ID_VALUE;
    rd_view[1] = ctrl_q;
    rd_view[2] = sts_i;
    rd_view[3] = REG_DW'(irq_stat_q);
    rd_view[4] = REG_DW'(irq_en_q);
    for (int i = 5; i < NREG; i++) rd_view[i] = scratch_q[i-5];
    rd_word = '0;
    for (int i = 0; i < NREG; i++) begin
      if (s_raddr == WAW'(i)) rd_word = rd_view[i];
    end
  end

  // Read data is captured from pre-write state, so a same-cycle write is not visible.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      StIdle: begin
        if (s_rvalid) begin
          state_d = StResp;
          rdata_d = rd_err ? '0 : rd_word;
          rerr_d  = rd_err;
        end
      end
      StResp: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wready_q   <= 1'b0;
      werr_q     <= 1'b0;
      start_q    <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
      rerr_q     <= 1'b0;
      ctrl_q     <= '0;
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      scratch_q  <= '{default: '0};
    end else begin
      state_q    <= state_d;
      wready_q   <= 1'b1;
      werr_q     <= wr_fire & wr_err;
      start_q    <= start_d;
      irq_q      <= |(irq_stat_q & irq_en_q);
      rdata_q    <= rdata_d;
      rerr_q     <= rerr_d;
      ctrl_q     <= ctrl_d;
      irq_stat_q <= irq_stat_d;
      irq_en_q   <= irq_en_d;
      scratch_q  <= scratch_d;
    end
  end

  assign s_wready  = wready_q;
  assign s_werr    = werr_q;
  assign s_rready  = (state_q == StResp);
  assign s_rdata   = rdata_q;
  assign s_rerr    = rerr_q & s_rready;
  assign cfg_ctrl  = ctrl_q;
  assign cfg_start = start_q;
  assign irq       = irq_q;

  for (genvar g = 0; g < NREG - 5; g++) begin : g_scratch
    assign cfg_scratch[g*REG_DW +: REG_DW] = scratch_q[g];
  end

endmodule

// File: tb/tb_asi_reg32_bank.sv
// Directed bench for asi_reg32_bank: read responses are checked against a scoreboard queue
// filled when each request is issued.
module tb_asi_reg32_bank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   s_wsize, s_rsize;
  logic [19:2]  s_waddr, s_raddr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic         s_wlast, s_wvalid, s_wready, s_werr;
  logic         s_rvalid, s_rready, s_rerr;
  logic [31:0]  s_rdata, cfg_ctrl, sts_i;
  logic         cfg_start, irq;
  logic [351:0] cfg_scratch;
  logic [7:0]   irq_evt;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int      checks = 0;
  int      errors = 0;

  always #5 clk = ~clk;

  asi_reg32_bank dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_wsize    (s_wsize),
    .s_waddr    (s_waddr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_wlast    (s_wlast),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .s_werr     (s_werr),
    .s_rsize    (s_rsize),
    .s_raddr    (s_raddr),
    .s_rvalid   (s_rvalid),
    .s_rdata    (s_rdata),
    .s_rready   (s_rready),
    .s_rerr     (s_rerr),
    .cfg_ctrl   (cfg_ctrl),
    .cfg_start  (cfg_start),
    .cfg_scratch(cfg_scratch),
    .sts_i      (sts_i),
    .irq_evt    (irq_evt),
    .irq        (irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [17:0] a, input logic [31:0] d, input logic [3:0] st,
                          input logic [2:0] sz, input logic exp_err, input string tag);
    s_waddr  = a;
    s_wdata  = d;
    s_wstrb  = st;
    s_wsize  = sz;
    s_wlast  = 1'b1;
    s_wvalid = 1'b1;
    step();
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
    chk({tag, " werr"}, 64'(s_werr), 64'(exp_err));
  endtask

  // Response must appear one cycle after the request edge, then s_rdata must hold.
  task automatic resp_check(input string tag);
    rd_exp_t e;
    chk({tag, " rready"}, 64'(s_rready), 64'(1'b1));
    e = exp_q.pop_front();
    chk({tag, " rdata"}, 64'(s_rdata), 64'(e.data));
    chk({tag, " rerr"}, 64'(s_rerr), 64'(e.err));
    step();
    chk({tag, " hold"}, {31'd0, s_rready, s_rdata}, {32'd0, e.data});
  endtask

  task automatic do_read(input logic [17:0] a, input logic [2:0] sz, input logic [31:0] ed,
                         input logic ee, input string tag);
    exp_q.push_back('{err: ee, data: ed});
    s_raddr  = a;
    s_rsize  = sz;
    s_rvalid = 1'b1;
    step();
    s_rvalid = 1'b0;
    resp_check(tag);
  endtask

  initial begin
    rst_n = 1'b0; s_wsize = 3'd2; s_rsize = 3'd2; s_waddr = '0; s_raddr = '0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_rvalid = 1'b0;
    sts_i = '0; irq_evt = '0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset outs", {s_wready, s_werr, s_rready, s_rerr, cfg_start, irq, s_rdata},
          64'd0);
    end
    chk("reset ctrl", 64'(cfg_ctrl), 64'd0);
    rst_n = 1'b1;
    step();
    chk("wready after reset", 64'(s_wready), 64'd1);
    do_read(18'd0, 3'd2, 32'h0A51_0001, 1'b0, "read id");

    do_write(18'd5, 32'hDEAD_BEEF, 4'b0101, 3'd2, 1'b0, "strb wr");
    chk("scratch5 out", 64'(cfg_scratch[31:0]), 64'h00AD_00EF);
    do_read(18'd5, 3'd2, 32'h00AD_00EF, 1'b0, "strb rd");

    do_write(18'd1, 32'h0000_0013, 4'hF, 3'd2, 1'b0, "ctrl wr");
    chk("start pulse", 64'(cfg_start), 64'd1);
    step();
    chk("start end", 64'(cfg_start), 64'd0);
    chk("cfg_ctrl", 64'(cfg_ctrl), 64'h12);
    do_read(18'd1, 3'd2, 32'h12, 1'b0, "ctrl rd");

    do_write(18'd4, 32'h04, 4'h1, 3'd2, 1'b0, "irq_en wr");
    irq_evt = 8'h04;
    step();
    irq_evt = 8'h00;
    chk("irq lag", 64'(irq), 64'd0);
    step();
    chk("irq set", 64'(irq), 64'd1);
    do_read(18'd3, 3'd2, 32'h04, 1'b0, "irq_stat rd");
    irq_evt = 8'h04;
    do_write(18'd3, 32'h04, 4'h1, 3'd2, 1'b0, "w1c+evt");
    irq_evt = 8'h00;
    do_read(18'd3, 3'd2, 32'h04, 1'b0, "set wins");
    do_write(18'd3, 32'h04, 4'h1, 3'd2, 1'b0, "w1c");
    chk("irq pre-clear", 64'(irq), 64'd1);
    step();
    chk("irq cleared", 64'(irq), 64'd0);
    do_read(18'd3, 3'd2, 32'h0, 1'b0, "irq_stat clr");

    do_write(18'd5, 32'h1111_2222, 4'hF, 3'd3, 1'b1, "bad wsize");
    step();
    chk("werr one cycle", 64'(s_werr), 64'd0);
    do_read(18'd5, 3'd2, 32'h00AD_00EF, 1'b0, "no update");
    do_write(18'd16, 32'h1, 4'hF, 3'd2, 1'b1, "wr oob");
    do_read(18'd16, 3'd2, 32'h0, 1'b1, "rd oob");
    do_read(18'd0, 3'd1, 32'h0, 1'b1, "bad rsize");
    do_write(18'd0, 32'hFFFF_FFFF, 4'hF, 3'd2, 1'b0, "wr id");
    do_read(18'd0, 3'd2, 32'h0A51_0001, 1'b0, "id intact");
    sts_i = 32'h1234_5678;
    do_read(18'd2, 3'd2, 32'h1234_5678, 1'b0, "status");

    do_write(18'd6, 32'h1, 4'hF, 3'd2, 1'b0, "wr6 old");
    s_waddr = 18'd6; s_wdata = 32'h2; s_wstrb = 4'hF; s_wsize = 3'd2; s_wvalid = 1'b1;
    s_raddr = 18'd6; s_rsize = 3'd2; s_rvalid = 1'b1;
    exp_q.push_back('{err: 1'b0, data: 32'h1});
    step();
    s_wvalid = 1'b0;
    s_rvalid = 1'b0;
    resp_check("rw same");
    chk("scratch6 out", 64'(cfg_scratch[63:32]), 64'h2);
    do_read(18'd6, 3'd2, 32'h2, 1'b0, "rw new");

    s_raddr = 18'd0; s_rvalid = 1'b1;
    s_waddr = 18'd7; s_wdata = 32'h55; s_wvalid = 1'b1;
    rst_n = 1'b0;
    step();
    s_rvalid = 1'b0;
    s_wvalid = 1'b0;
    chk("rst drops resp", 64'(s_rready), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rst stays idle", 64'(s_rready), 64'd0);
    chk("rst ctrl", 64'(cfg_ctrl), 64'd0);
    do_read(18'd7, 3'd2, 32'h0, 1'b0, "inflight wr");
    do_read(18'd5, 3'd2, 32'h0, 1'b0, "scratch rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
